filter_load_ctrl: RTL and testbench
===================================

# filter_load_ctrl

Sequencing controller that fills the 5x5 filter coefficient array from coefficient memory ahead of the convolution engine. On a `start` command it fetches 9 words (3x3 kernel) or 25 words (5x5 kernel) from consecutive addresses through a single-outstanding read port. It assembles the words row-major into a 5x5 array of 16-bit coefficients, zero-padding when the kernel is 3x3. It then presents the array with `filter_valid` until the convolution engine releases it.

## Interface
- `DATA_W`, 16, coefficient width (signed, shortint-compatible)
- `ADDR_W`, 16, coefficient memory address width
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  load command, sampled on rising edge
- `ksize`  in  1  kernel size: 0 = 3x3, 1 = 5x5; sampled with `start`
- `base_addr`  in  ADDR_W  first coefficient address; sampled with `start`
- `release`  in  1  consumer finished with current filter
- `rd_en`  out  1  memory read request, one-cycle pulse
- `rd_addr`  out  ADDR_W  read address, valid while `rd_en`=1
- `rd_valid`  in  1  read data returned
- `rd_data`  in  DATA_W  returned coefficient
- `filter_out`  out  25*DATA_W  packed array; element [r][c] at bits (r*5+c)*DATA_W +: DATA_W
- `filter_valid`  out  1  `filter_out` complete and stable
- `done`  out  1  one-cycle pulse when a load completes
- `busy`  out  1  load in progress (states REQ and WAIT)

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - `start`=1 → latch `ksize`, `base_addr`; clear all 25 array entries to 0; k=0; go to REQ.
- REQ:
  - `rd_en`=1, `rd_addr` = base_addr + k (mod 2^ADDR_W); go to WAIT.
- WAIT:
  - On `rd_valid`, write `rd_data` to entry [k/K][k%K], where K = 3 or 5.
  - If k = K*K-1 → HOLD, with `filter_valid` and `done` asserted the next cycle.
  - Otherwise k++ and go to REQ.
- HOLD:
  - `filter_valid`=1; array frozen.
  - `release`=1 → IDLE, `filter_valid` drops.
  - `start`=1 → reload exactly as from IDLE; `filter_valid` drops at the same edge.
  - `start` and `release` in the same cycle → `start` wins.
- Ignored inputs:
  - `start` while `busy`=1.
  - `release` outside HOLD.
  - `rd_valid` outside WAIT.
- 3x3 loads leave row 3, row 4, column 3 and column 4 at 0.
- Coefficient index k is 5 bits; never exceeds 24.

## Timing
- Reset (async assert, sync release): state IDLE.
  - Outputs: `rd_en`=0, `rd_addr`=0, `filter_out`=0, `filter_valid`=0, `done`=0, `busy`=0.
- Reset mid-load aborts the load immediately; no partial filter is presented.
- Let `start` be sampled at edge 0:
  - `rd_en` is high in cycle 1 with `rd_addr`=base.
  - `busy`=1 from cycle 1.
- Memory latency L ≥ 1: `rd_valid` arrives L cycles after the `rd_en` cycle.
  - Each word takes L+1 cycles.
  - At most one read outstanding; the next `rd_en` comes the cycle after `rd_valid`.
- Completion: `filter_valid` and `done` rise in cycle N*(L+1)+1, where N = 9 or 25.
  - `busy` falls in the same cycle.
  - `done` is high for exactly one cycle.
- `filter_out` entries update one cycle after their `rd_valid`.
- `filter_out` is unchanged in HOLD and IDLE until the next accepted `start`, which clears it.

## Test plan
- 5x5 load, L=1, `base_addr`=0x0100, memory returns addr-0x00FF (1..25):
  - `rd_addr` sequence 0x0100..0x0118.
  - `filter_valid` and `done` at cycle 51.
  - [0][0]=1, [2][3]=14, [4][4]=25.
- 3x3 load, L=3, `base_addr`=0x0040, data 0x8001..0x8009:
  - `filter_valid` at cycle 37.
  - [0][0]=0x8001, [2][2]=0x8009.
  - All entries with r ≥ 3 or c ≥ 3 are 0.
- Address wrap: 3x3 load, `base_addr`=0xFFFE:
  - Addresses FFFE, FFFF, 0000 … 0006.
- `start` pulses during a 5x5 load, plus stray `rd_valid` during REQ:
  - Ignored; load completes with the original data and timing.
- In HOLD:
  - `release` alone → IDLE; `filter_valid`=0 next cycle; `filter_out` retained.
  - `start`+`release` together → new load begins, `rd_en` the next cycle, array cleared.
- Assert `rst_n`=0 for 1 cycle after word 12 of a 5x5 load:
  - All outputs 0 immediately.
  - No `done`.
  - A subsequent fresh `start` completes normally.

Source files
------------

// File: rtl/filter_load_ctrl.sv
// Coefficient load sequencer: fetches a 3x3 or 5x5 kernel word-by-word through a
// single-outstanding read port and holds it as a zero-padded 5x5 array for the engine.
module filter_load_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  ksize,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  release_in,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic                  rd_valid,
    input  logic [DATA_W-1:0]     rd_data,
    output logic [25*DATA_W-1:0]  filter_out,
    output logic                  filter_valid,
    output logic                  done,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]               state_q, state_d;
    logic                     ksize_q, ksize_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [4:0]               k_q, k_d;
    logic [2:0]               row_q, row_d;
    logic [2:0]               col_q, col_d;
    logic [24:0][DATA_W-1:0]  filter_q, filter_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic                     filter_valid_q, filter_valid_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic [2:0]               col_max_s;
    logic [4:0]               k_last_s;

    // Row/column are tracked alongside k so the 5-wide array slot needs no divider.
    function automatic logic [4:0] coef_index(input logic [2:0] row, input logic [2:0] col);
        return ({2'b00, row} * 5'd5) + {2'b00, col};
    endfunction

    // Kernel geometry of the load in progress.
    always_comb begin
        if (ksize_q) begin
            col_max_s = 3'd4;
            k_last_s  = 5'd24;
        end else begin
            col_max_s = 3'd2;
            k_last_s  = 5'd8;
        end
    end

    // Next-state, array update and registered-output computation.
    always_comb begin
        state_d  = state_q;
        ksize_d  = ksize_q;
        base_d   = base_q;
        k_d      = k_q;
        row_d    = row_q;
        col_d    = col_q;
        filter_d = filter_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE, S_HOLD: begin
                // start outranks release so a queued reload is never lost.
                if (start) begin
                    ksize_d  = ksize;
                    base_d   = base_addr;
                    k_d      = 5'd0;
                    row_d    = 3'd0;
                    col_d    = 3'd0;
                    filter_d = '0;
                    state_d  = S_REQ;
                end else if ((state_q == S_HOLD) && release_in) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rd_valid) begin
                    filter_d[coef_index(row_q, col_q)] = rd_data;
                    if (k_q == k_last_s) begin
                        done_d  = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        k_d     = k_q + 5'd1;
                        state_d = S_REQ;
                        if (col_q == col_max_s) begin
                            col_d = 3'd0;
                            row_d = row_q + 3'd1;
                        end else begin
                            col_d = col_q + 3'd1;
                            row_d = row_q;
                        end
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d        = (state_d == S_REQ);
        busy_d         = (state_d == S_REQ) || (state_d == S_WAIT);
        filter_valid_d = (state_d == S_HOLD);
        if (state_d == S_REQ) begin
            rd_addr_d = base_d + ADDR_W'(k_d);
        end else begin
            rd_addr_d = rd_addr_q;
        end
    end

    // State and output registers; reset aborts any load in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ksize_q        <= 1'b0;
            base_q         <= '0;
            k_q            <= 5'd0;
            row_q          <= 3'd0;
            col_q          <= 3'd0;
            filter_q       <= '0;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            filter_valid_q <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ksize_q        <= ksize_d;
            base_q         <= base_d;
            k_q            <= k_d;
            row_q          <= row_d;
            col_q          <= col_d;
            filter_q       <= filter_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            filter_valid_q <= filter_valid_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
        end
    end

    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign filter_out   = filter_q;
    assign filter_valid = filter_valid_q;
    assign done         = done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_filter_load_ctrl.sv
// Directed bench for filter_load_ctrl: a latency-programmable memory model answers reads,
// and each scenario task checks timing, addresses and array contents against hand values.
module tb_filter_load_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         ksize;
    logic [15:0]  base_addr;
    logic         release_in;
    logic         rd_en;
    logic [15:0]  rd_addr;
    logic         rd_valid;
    logic [15:0]  rd_data;
    logic [399:0] filter_out;
    logic         filter_valid;
    logic         done;
    logic         busy;

    logic         mem_valid;
    logic [15:0]  mem_data;
    logic         stray_valid;
    logic [15:0]  stray_data;
    int           mem_lat;
    logic [15:0]  mem_add;
    logic [15:0]  addr_q[$];
    int           cyc;
    int           total;
    int           bad;

    always #5 clk = ~clk;

    assign rd_valid = mem_valid | stray_valid;
    assign rd_data  = stray_valid ? stray_data : mem_data;

    filter_load_ctrl #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ksize(ksize), .base_addr(base_addr),
        .release_in(release_in), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .filter_out(filter_out), .filter_valid(filter_valid),
        .done(done), .busy(busy)
    );

    // Memory model: data = addr + mem_add, returned mem_lat cycles after the rd_en cycle.
    initial begin : mem_model
        logic        pend;
        int          cnt;
        logic [15:0] paddr;
        pend = 1'b0; cnt = 0; paddr = 16'h0000;
        mem_valid = 1'b0; mem_data = 16'h0000;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_valid = 1'b1;
                        mem_data  = paddr + mem_add;
                        pend      = 1'b0;
                    end
                end
                if (rd_en === 1'b1) begin
                    pend  = 1'b1;
                    cnt   = mem_lat;
                    paddr = rd_addr;
                    addr_q.push_back(rd_addr);
                end
            end
        end
    end

    function automatic logic [15:0] ent(input logic [399:0] f, input int r, input int c);
        return f[(r*5+c)*16 +: 16];
    endfunction

    // Start is sampled at the edge after this call's first negedge; returns in cycle 1.
    task automatic issue_start(input logic ks, input logic [15:0] b, input logic rel);
        @(negedge clk);
        start = 1'b1; ksize = ks; base_addr = b; release_in = rel;
        addr_q.delete();
        @(negedge clk);
        start = 1'b0; release_in = 1'b0;
        cyc = 1;
    endtask

    task automatic run_to_valid(input int limit, output int early);
        early = 0;
        while (filter_valid !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1 && filter_valid !== 1'b1) early++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rd_en !== 1'b0) begin $display("FAIL reset_rd_en got=%b exp=0", rd_en); bad++; end
        total++; if (rd_addr !== 16'h0000) begin $display("FAIL reset_rd_addr got=%h exp=0000", rd_addr); bad++; end
        total++; if (filter_out !== 400'd0) begin $display("FAIL reset_filter_out got nonzero"); bad++; end
        total++; if (filter_valid !== 1'b0) begin $display("FAIL reset_filter_valid got=%b exp=0", filter_valid); bad++; end
        total++; if (done !== 1'b0) begin $display("FAIL reset_done got=%b exp=0", done); bad++; end
        total++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); bad++; end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_5x5;
        int early; int errs;
        mem_lat = 1; mem_add = 16'hFF01;
        issue_start(1'b1, 16'h0100, 1'b0);
        total++; if (rd_en !== 1'b1 || rd_addr !== 16'h0100) begin $display("FAIL l5_first_req got en=%b addr=%h exp en=1 addr=0100", rd_en, rd_addr); bad++; end
        total++; if (busy !== 1'b1) begin $display("FAIL l5_busy got=%b exp=1", busy); bad++; end
        run_to_valid(200, early);
        total++; if (cyc !== 51) begin $display("FAIL l5_valid_cycle got=%0d exp=51", cyc); bad++; end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin $display("FAIL l5_done_busy got done=%b busy=%b exp 1 0", done, busy); bad++; end
        total++; if (early !== 0) begin $display("FAIL l5_early_done got=%0d exp=0", early); bad++; end
        errs = 0;
        for (int i = 0; i < 25; i++) if (addr_q.size() <= i || addr_q[i] !== 16'(16'h0100 + i)) errs++;
        total++; if (errs !== 0 || addr_q.size() !== 25) begin $display("FAIL l5_addr_seq got errs=%0d n=%0d exp errs=0 n=25", errs, addr_q.size()); bad++; end
        errs = 0;
        for (int i = 0; i < 25; i++) if (filter_out[i*16 +: 16] !== 16'(i + 1)) errs++;
        total++; if (errs !== 0) begin $display("FAIL l5_array got errs=%0d exp=0", errs); bad++; end
        total++; if (ent(filter_out, 0, 0) !== 16'd1 || ent(filter_out, 2, 3) !== 16'd14 || ent(filter_out, 4, 4) !== 16'd25)
            begin $display("FAIL l5_corners got %h %h %h exp 0001 000e 0019", ent(filter_out, 0, 0), ent(filter_out, 2, 3), ent(filter_out, 4, 4)); bad++; end
        @(negedge clk);
        total++; if (done !== 1'b0 || filter_valid !== 1'b1) begin $display("FAIL l5_done_pulse got done=%b fv=%b exp 0 1", done, filter_valid); bad++; end
    endtask

    task automatic test_release;
        release_in = 1'b1;
        @(negedge clk);
        release_in = 1'b0;
        total++; if (filter_valid !== 1'b0) begin $display("FAIL rel_fv got=%b exp=0", filter_valid); bad++; end
        total++; if (ent(filter_out, 4, 4) !== 16'd25 || ent(filter_out, 0, 0) !== 16'd1) begin $display("FAIL rel_retain got %h %h exp 0019 0001", ent(filter_out, 4, 4), ent(filter_out, 0, 0)); bad++; end
        repeat (3) @(negedge clk);
        total++; if (filter_valid !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) begin $display("FAIL rel_idle got fv=%b en=%b busy=%b exp 0 0 0", filter_valid, rd_en, busy); bad++; end
    endtask

    task automatic test_load_3x3;
        int early; int errs;
        mem_lat = 3; mem_add = 16'h7FC1;
        issue_start(1'b0, 16'h0040, 1'b0);
        total++; if (filter_out !== 400'd0) begin $display("FAIL l3_clear got nonzero array exp 0"); bad++; end
        run_to_valid(200, early);
        total++; if (cyc !== 37 || done !== 1'b1) begin $display("FAIL l3_valid_cycle got=%0d done=%b exp=37 done=1", cyc, done); bad++; end
        total++; if (ent(filter_out, 0, 0) !== 16'h8001 || ent(filter_out, 2, 2) !== 16'h8009) begin $display("FAIL l3_corners got %h %h exp 8001 8009", ent(filter_out, 0, 0), ent(filter_out, 2, 2)); bad++; end
        errs = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (r >= 3 || c >= 3) begin
                    if (ent(filter_out, r, c) !== 16'h0000) errs++;
                end else begin
                    if (ent(filter_out, r, c) !== 16'(16'h8001 + r*3 + c)) errs++;
                end
        total++; if (errs !== 0) begin $display("FAIL l3_array got errs=%0d exp=0", errs); bad++; end
    endtask

    task automatic test_wrap;
        int early; int errs;
        mem_lat = 1; mem_add = 16'h7FC1;
        issue_start(1'b0, 16'hFFFE, 1'b0);
        total++; if (filter_valid !== 1'b0 || rd_addr !== 16'hFFFE) begin $display("FAIL wrap_restart got fv=%b addr=%h exp 0 fffe", filter_valid, rd_addr); bad++; end
        run_to_valid(200, early);
        total++; if (cyc !== 19) begin $display("FAIL wrap_valid_cycle got=%0d exp=19", cyc); bad++; end
        errs = 0;
        for (int i = 0; i < 9; i++) if (addr_q.size() <= i || addr_q[i] !== 16'(16'hFFFE + i)) errs++;
        total++; if (errs !== 0 || addr_q.size() !== 9) begin $display("FAIL wrap_addr_seq got errs=%0d n=%0d exp errs=0 n=9", errs, addr_q.size()); bad++; end
        total++; if (ent(filter_out, 0, 2) !== 16'h7FC1 || ent(filter_out, 2, 2) !== 16'h7FC7) begin $display("FAIL wrap_data got %h %h exp 7fc1 7fc7", ent(filter_out, 0, 2), ent(filter_out, 2, 2)); bad++; end
    endtask

    task automatic test_ignored;
        int early; int errs;
        mem_lat = 1; mem_add = 16'hFF01;
        issue_start(1'b1, 16'h0200, 1'b0);
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        total++; if (rd_en !== 1'b1) begin $display("FAIL ign_req_cycle got en=%b exp=1", rd_en); bad++; end
        stray_valid = 1'b1; stray_data = 16'hDEAD;
        @(negedge clk); cyc++;
        stray_valid = 1'b0;
        start = 1'b1; ksize = 1'b0; base_addr = 16'h1234;
        @(negedge clk); cyc++;
        start = 1'b0;
        while (cyc < 10) begin @(negedge clk); cyc++; end
        start = 1'b1; release_in = 1'b1;
        @(negedge clk); cyc++;
        start = 1'b0; release_in = 1'b0;
        total++; if (busy !== 1'b1) begin $display("FAIL ign_busy got=%b exp=1", busy); bad++; end
        run_to_valid(200, early);
        total++; if (cyc !== 51 || early !== 0) begin $display("FAIL ign_valid_cycle got=%0d early=%0d exp=51 early=0", cyc, early); bad++; end
        errs = 0;
        for (int i = 0; i < 25; i++) if (addr_q.size() <= i || addr_q[i] !== 16'(16'h0200 + i)) errs++;
        total++; if (errs !== 0 || addr_q.size() !== 25) begin $display("FAIL ign_addr_seq got errs=%0d n=%0d exp errs=0 n=25", errs, addr_q.size()); bad++; end
        errs = 0;
        for (int i = 0; i < 25; i++) if (filter_out[i*16 +: 16] !== 16'(16'h0101 + i)) errs++;
        total++; if (errs !== 0) begin $display("FAIL ign_array got errs=%0d exp=0", errs); bad++; end
    endtask

    task automatic test_start_release;
        int early;
        mem_lat = 1; mem_add = 16'hFF01;
        issue_start(1'b0, 16'h0300, 1'b1);
        total++; if (rd_en !== 1'b1 || rd_addr !== 16'h0300) begin $display("FAIL sr_req got en=%b addr=%h exp 1 0300", rd_en, rd_addr); bad++; end
        total++; if (filter_out !== 400'd0 || filter_valid !== 1'b0) begin $display("FAIL sr_clear got fv=%b nonzero=%b exp 0 0", filter_valid, |filter_out); bad++; end
        run_to_valid(200, early);
        total++; if (cyc !== 19 || ent(filter_out, 0, 0) !== 16'h0201 || ent(filter_out, 2, 2) !== 16'h0209)
            begin $display("FAIL sr_load got cyc=%0d %h %h exp 19 0201 0209", cyc, ent(filter_out, 0, 0), ent(filter_out, 2, 2)); bad++; end
    endtask

    task automatic test_reset_mid;
        int early; int dn; int fv;
        mem_lat = 1; mem_add = 16'hFF01;
        issue_start(1'b1, 16'h0100, 1'b0);
        while (cyc < 25) begin @(negedge clk); cyc++; end
        total++; if (ent(filter_out, 2, 1) !== 16'd12 || filter_valid !== 1'b0) begin $display("FAIL rm_partial got %h fv=%b exp 000c 0", ent(filter_out, 2, 1), filter_valid); bad++; end
        rst_n = 1'b0;
        #1;
        total++; if (rd_en !== 1'b0 || rd_addr !== 16'h0000 || busy !== 1'b0) begin $display("FAIL rm_outs got en=%b addr=%h busy=%b exp 0 0000 0", rd_en, rd_addr, busy); bad++; end
        total++; if (filter_out !== 400'd0 || filter_valid !== 1'b0 || done !== 1'b0) begin $display("FAIL rm_filter got nz=%b fv=%b done=%b exp 0 0 0", |filter_out, filter_valid, done); bad++; end
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0; fv = 0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
            if (filter_valid === 1'b1) fv++;
        end
        total++; if (dn !== 0 || fv !== 0) begin $display("FAIL rm_no_done got done=%0d fv=%0d exp 0 0", dn, fv); bad++; end
        mem_lat = 2;
        issue_start(1'b0, 16'h0100, 1'b0);
        run_to_valid(200, early);
        total++; if (cyc !== 28 || done !== 1'b1 || early !== 0) begin $display("FAIL rm_fresh_cycle got=%0d done=%b early=%0d exp 28 1 0", cyc, done, early); bad++; end
        total++; if (ent(filter_out, 0, 0) !== 16'd1 || ent(filter_out, 2, 2) !== 16'd9 || ent(filter_out, 3, 3) !== 16'd0)
            begin $display("FAIL rm_fresh_data got %h %h %h exp 0001 0009 0000", ent(filter_out, 0, 0), ent(filter_out, 2, 2), ent(filter_out, 3, 3)); bad++; end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        start = 1'b0; ksize = 1'b0; base_addr = 16'h0000; release_in = 1'b0;
        stray_valid = 1'b0; stray_data = 16'h0000;
        mem_lat = 1; mem_add = 16'h0000;
        test_reset;
        test_load_5x5;
        test_release;
        test_load_3x3;
        test_wrap;
        test_ignored;
        test_start_release;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
